// File: rtl/id_exe_skid.sv
// Elastic ID/EX pipeline register: two-entry skid buffer between decode and execute
// with in-block flush and zero-control bubbles on an empty output slot.
module id_exe_skid #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] id_data,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    output logic              exe_valid,
    input  logic              exe_ready,
    output logic [DATA_W-1:0] exe_data,
    output logic [CTRL_W-1:0] exe_ctrl,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t main_q, skid_q, in_e;
    logic   main_vld, skid_vld, rdy_q;
    logic   accept, fire, skid_nxt;

    assign in_e   = '{ctrl: id_ctrl, data: id_data};
    assign accept = id_valid & rdy_q;
    assign fire   = main_vld & exe_ready;

    // Skid fills only when a second instruction arrives while main is stuck;
    // it drains whenever main fires. id_ready is its registered complement.
    assign skid_nxt = skid_vld ? ~fire : (main_vld & accept & ~fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b0;
        end else if (flush) begin
            main_vld    <= 1'b0;
            skid_vld    <= 1'b0;
            main_q.ctrl <= '0;
            skid_q.ctrl <= '0;
            rdy_q       <= 1'b1;
        end else begin
            case ({skid_vld, main_vld})
                2'b00: begin
                    if (accept) begin
                        main_q   <= in_e;
                        main_vld <= 1'b1;
                    end
                end
                2'b01: begin
                    if (accept && fire) begin
                        main_q <= in_e;
                    end else if (accept) begin
                        skid_q   <= in_e;
                        skid_vld <= 1'b1;
                    end else if (fire) begin
                        main_vld <= 1'b0;
                    end
                end
                default: begin
                    if (fire) begin
                        main_q   <= skid_q;
                        skid_vld <= 1'b0;
                    end
                end
            endcase
            rdy_q <= ~skid_nxt;
        end
    end

    assign id_ready  = rdy_q;
    assign exe_valid = main_vld;
    assign exe_data  = main_q.data;
    assign exe_ctrl  = main_vld ? main_q.ctrl : '0;
    assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: tb/tb_id_exe_skid.sv
// Bench for id_exe_skid: queue-level FIFO model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_id_exe_skid;
    localparam int DATA_W = 128;
    localparam int CTRL_W = 16;

    logic              clk = 1'b0;
    logic              rst, id_valid, flush, exe_ready;
    logic              id_ready, exe_valid;
    logic [DATA_W-1:0] id_data, exe_data;
    logic [CTRL_W-1:0] id_ctrl, exe_ctrl;
    logic [1:0]        occupancy;

    id_exe_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_data(id_data), .id_ctrl(id_ctrl), .flush(flush),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_data(exe_data),
        .exe_ctrl(exe_ctrl), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } item_t;

    item_t             mq[$];
    logic              ready_m = 1'b0;
    bit                started = 1'b0;
    logic [DATA_W-1:0] fired[$];
    int                n_cmp = 0;
    int                n_bad = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a FIFO of at most two items.
    always @(posedge clk) begin
        bit acc;
        started = 1'b1;
        if (rst) begin
            mq.delete();
            ready_m = 1'b0;
        end else if (flush) begin
            mq.delete();
            ready_m = 1'b1;
        end else begin
            acc = id_valid && ready_m;
            if (mq.size() > 0 && exe_ready) void'(mq.pop_front());
            if (acc) mq.push_back('{data: id_data, ctrl: id_ctrl});
            ready_m = (mq.size() < 2);
        end
    end

    // Record what execute actually consumed (flush/reset cycles discard).
    always @(posedge clk) begin
        if (!rst && !flush && exe_valid === 1'b1 && exe_ready) fired.push_back(exe_data);
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_valid", {127'd0, exe_valid}, {127'd0, mq.size() > 0});
            chk("m_occ", {126'd0, occupancy}, DATA_W'(mq.size()));
            chk("m_ready", {127'd0, id_ready}, {127'd0, ready_m});
            chk("m_ctrl", {112'd0, exe_ctrl}, mq.size() > 0 ? {112'd0, mq[0].ctrl} : '0);
            if (mq.size() > 0) chk("m_data", exe_data, mq[0].data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        id_valid = 1'b1;
        id_data  = d;
        id_ctrl  = c;
    endtask

    task automatic chk_fired(input string nm, input logic [DATA_W-1:0] exp[$]);
        chk({nm, "_cnt"}, DATA_W'(fired.size()), DATA_W'(exp.size()));
        for (int i = 0; i < exp.size() && i < fired.size(); i++) chk(nm, fired[i], exp[i]);
    endtask

    initial begin
        logic [DATA_W-1:0] e[$];
        rst = 1'b1; id_valid = 1'b1; id_ctrl = 16'hFFFF; id_data = 128'h1234;
        flush = 1'b0; exe_ready = 1'b0;

        // Reset
        cyc(); cyc();
        chk("rst_valid", {127'd0, exe_valid}, 0);
        chk("rst_ctrl", {112'd0, exe_ctrl}, 0);
        chk("rst_data", exe_data, 0);
        chk("rst_occ", {126'd0, occupancy}, 0);
        chk("rst_ready", {127'd0, id_ready}, 0);
        rst = 1'b0; id_valid = 1'b0;
        cyc();
        chk("rel_ready", {127'd0, id_ready}, 1);

        // Streaming
        exe_ready = 1'b1; fired.delete();
        send(128'h20010005, 16'h0081); cyc();
        chk("s0_data", exe_data, 128'h20010005);
        chk("s0_occ", {126'd0, occupancy}, 1);
        send(128'h20020007, 16'h0081); cyc();
        chk("s1_data", exe_data, 128'h20020007);
        send(128'h00221820, 16'h0109); cyc();
        chk("s2_data", exe_data, 128'h00221820);
        chk("s2_ctrl", {112'd0, exe_ctrl}, 16'h0109);
        id_valid = 1'b0; cyc();
        e = '{128'h20010005, 128'h20020007, 128'h00221820};
        chk_fired("s_order", e);

        // Backpressure
        exe_ready = 1'b0; fired.delete();
        send(128'hA, 16'h0001); cyc();
        send(128'hB, 16'h0002); cyc();
        chk("bp_occ", {126'd0, occupancy}, 2);
        chk("bp_ready", {127'd0, id_ready}, 0);
        send(128'hC, 16'h0003); cyc();
        chk("bp_hold", exe_data, 128'hA);
        chk("bp_occ2", {126'd0, occupancy}, 2);
        exe_ready = 1'b1; cyc();
        chk("bp_b", exe_data, 128'hB);
        chk("bp_ready2", {127'd0, id_ready}, 1);
        cyc(); id_valid = 1'b0;
        chk("bp_c", exe_data, 128'hC);
        cyc();
        e = '{128'hA, 128'hB, 128'hC};
        chk_fired("bp_order", e);

        // Flush colliding with accept and fire
        exe_ready = 1'b0;
        send(128'h11, 16'h0011); cyc();
        send(128'h22, 16'h0022); cyc();
        chk("fl_pre_occ", {126'd0, occupancy}, 2);
        fired.delete();
        send(128'h33, 16'h0033); flush = 1'b1; exe_ready = 1'b1; cyc();
        flush = 1'b0; id_valid = 1'b0;
        chk("fl_valid", {127'd0, exe_valid}, 0);
        chk("fl_ctrl", {112'd0, exe_ctrl}, 0);
        chk("fl_occ", {126'd0, occupancy}, 0);
        chk("fl_ready", {127'd0, id_ready}, 1);
        cyc(); cyc();
        chk("fl_none", DATA_W'(fired.size()), 0);

        // Bubble after drain
        send(128'hDEADBEEF, 16'h0044); cyc();
        chk("bub_ctrl", {112'd0, exe_ctrl}, 16'h0044);
        id_valid = 1'b0; cyc();
        chk("bub_valid", {127'd0, exe_valid}, 0);
        chk("bub_ctrl0", {112'd0, exe_ctrl}, 0);
        chk("bub_data", exe_data, 128'hDEADBEEF);
        cyc();
        chk("bub_ctrl1", {112'd0, exe_ctrl}, 0);

        // Reset mid-operation
        exe_ready = 1'b0;
        send(128'h51, 16'h0051); cyc();
        send(128'h52, 16'h0052); cyc();
        chk("mr_occ", {126'd0, occupancy}, 2);
        id_valid = 1'b0; rst = 1'b1; flush = 1'b1; cyc();
        rst = 1'b0; flush = 1'b0;
        chk("mr_valid", {127'd0, exe_valid}, 0);
        chk("mr_data", exe_data, 0);
        chk("mr_occ0", {126'd0, occupancy}, 0);
        chk("mr_ready", {127'd0, id_ready}, 0);
        cyc();
        chk("mr_ready1", {127'd0, id_ready}, 1);
        send(128'h53, 16'h0053); cyc();
        chk("mr_new", exe_data, 128'h53);
        chk("mr_new_occ", {126'd0, occupancy}, 1);
        id_valid = 1'b0; exe_ready = 1'b1; fired.delete(); cyc(); cyc();
        e = '{128'h53};
        chk_fired("mr_order", e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
